dbg_port_mh: RTL and testbench

Multi-hart debug port dispatcher between the DMI-side debug transport and NHARTS River cores. Accepts one debug request at a time, routes it by hart select to that hart's CSR port or integer register bank, and keeps a per-hart stack-trace depth counter. Extends the single-hart debug port with parametrised hart count, per-access size masking, a response timeout with error reporting, and error responses for invalid hart or region.

---
 rtl/dbg_port_mh_pkg.sv | 60 ++++++
 rtl/dbg_port_mh_stktr_counter.sv | 42 ++++
 rtl/dbg_port_mh.sv | 263 ++++++++++++++++++++++++++
 tb/tb_dbg_port_mh.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_port_mh_pkg.sv
// Shared definitions for the multi-hart debug port dispatcher.
//   - state_t     : dispatcher FSM states (4-bit encoding, IDLE=0 .. RESP=5)
//   - REGION_*    : request region codes
//   - ctrl_t      : registered control state of the dispatcher, CTRL_RESET is its reset value
//   - size_mask() : byte-lane mask for an access size (8/16/32/full bits)
package dbg_port_mh_pkg;

  localparam int MAX_ARCH = 64;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_CSR_REQ  = 4'd1,
    ST_CSR_RESP = 4'd2,
    ST_REG_ACC  = 4'd3,
    ST_REG_CAP  = 4'd4,
    ST_RESP     = 4'd5
  } state_t;

  localparam logic [1:0] REGION_CSR   = 2'd0;
  localparam logic [1:0] REGION_IREG  = 2'd1;
  localparam logic [1:0] REGION_STKTR = 2'd2;
  localparam logic [1:0] REGION_RSVD  = 2'd3;

  typedef struct packed {
    state_t     state;
    logic       write;           // latched request direction
    logic [1:0] size;            // latched access size
    logic [7:0] tmo_cnt;         // CSR response timeout counter
    logic       error;
    logic       resp_valid;
    logic       req_ready;
    logic       csr_resp_ready;
    logic       ireg_write;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{
    state:          ST_IDLE,
    write:          1'b0,
    size:           2'd0,
    tmo_cnt:        8'd0,
    error:          1'b0,
    resp_valid:     1'b0,
    req_ready:      1'b1,
    csr_resp_ready: 1'b1,
    ireg_write:     1'b0
  };

  function automatic logic [MAX_ARCH-1:0] size_mask(input logic [1:0] size);
    logic [MAX_ARCH-1:0] m;
    m = '0;
    case (size)
      2'd0:    m[7:0]  = '1;
      2'd1:    m[15:0] = '1;
      2'd2:    m[31:0] = '1;
      default: m       = '1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dbg_port_mh_stktr_counter.sv
// Per-hart stack-trace depth counter.
//   clk, rst_n      : clock, asynchronous active-low reset
//   call, ret       : call / return commit pulses
//   wr_en, wr_data  : debug load; has priority over call/ret
//   cnt             : current depth, saturates at 2^W-1 and holds at 0
module stktr_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         call,
  input  logic         ret,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (wr_en) begin
      cnt_next = wr_data;
    end else if (call && !ret && (cnt_reg != '1)) begin
      cnt_next = cnt_reg + 1'b1;
    end else if (ret && !call && (cnt_reg != '0)) begin
      cnt_next = cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/dbg_port_mh.sv
// Multi-hart debug port dispatcher. Accepts one debug request at a time and
// routes it by hart select to that hart's CSR port, integer register bank or
// stack-trace depth counter; answers with a single registered response.
// Ports:
//   i_dport_*  / o_dport_*  : DMI-side request/response handshake
//   o_csr_req_* / i_csr_*   : per-hart CSR request/response (valid one-hot, fields shared)
//   o_ireg_*   / i_ireg_rdata : per-hart regbank strobe (one-hot) and read data
//   i_e_call, i_e_ret       : per-hart call/return commit pulses
//   o_stktr_cnt             : packed per-hart stack-trace depth
module dbg_port_mh
  import dbg_port_mh_pkg::*;
#(
  parameter int NHARTS     = 4,
  parameter int ARCH       = 64,
  parameter int STKTR_LOG2 = 5,
  parameter int TMO        = 255,
  localparam int HW        = (NHARTS > 1) ? $clog2(NHARTS) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_nrst,
  input  logic                         i_dport_req_valid,
  output logic                         o_dport_req_ready,
  input  logic [HW-1:0]                i_dport_hartsel,
  input  logic [1:0]                   i_dport_region,
  input  logic [11:0]                  i_dport_idx,
  input  logic                         i_dport_write,
  input  logic [1:0]                   i_dport_size,
  input  logic [ARCH-1:0]              i_dport_wdata,
  output logic                         o_dport_resp_valid,
  input  logic                         i_dport_resp_ready,
  output logic                         o_dport_resp_error,
  output logic [ARCH-1:0]              o_dport_rdata,
  output logic [NHARTS-1:0]            o_csr_req_valid,
  input  logic [NHARTS-1:0]            i_csr_req_ready,
  output logic                         o_csr_req_write,
  output logic [11:0]                  o_csr_req_addr,
  output logic [ARCH-1:0]              o_csr_req_data,
  input  logic [NHARTS-1:0]            i_csr_resp_valid,
  output logic                         o_csr_resp_ready,
  input  logic [NHARTS*ARCH-1:0]       i_csr_resp_data,
  input  logic [NHARTS-1:0]            i_csr_resp_exception,
  output logic [NHARTS-1:0]            o_ireg_ena,
  output logic                         o_ireg_write,
  output logic [5:0]                   o_ireg_addr,
  output logic [ARCH-1:0]              o_ireg_wdata,
  input  logic [NHARTS*ARCH-1:0]       i_ireg_rdata,
  input  logic [NHARTS-1:0]            i_e_call,
  input  logic [NHARTS-1:0]            i_e_ret,
  output logic [NHARTS*STKTR_LOG2-1:0] o_stktr_cnt
);

  ctrl_t                 ctrl_reg, ctrl_next;
  logic [HW-1:0]         hart_reg, hart_next;
  logic [11:0]           idx_reg, idx_next;
  logic [ARCH-1:0]       wdata_reg, wdata_next;
  logic [ARCH-1:0]       rdata_reg, rdata_next;
  logic [NHARTS-1:0]     csr_req_valid_reg, csr_req_valid_next;
  logic [NHARTS-1:0]     ireg_ena_reg, ireg_ena_next;

  logic [MAX_ARCH-1:0]   in_mask_full, cur_mask_full;
  logic [ARCH-1:0]       in_mask, cur_mask, wdata_masked;
  logic [NHARTS-1:0]     req_sel;    // decoded incoming hartsel, all-zero when out of range
  logic [NHARTS-1:0]     cur_sel;    // decoded latched hart
  logic                  hart_ok;
  logic                  accept;
  logic [NHARTS-1:0]     stktr_wr;
  logic [STKTR_LOG2-1:0] cnt_arr [NHARTS];
  logic [STKTR_LOG2-1:0] cnt_sel;
  logic [ARCH-1:0]       csr_data_sel, ireg_data_sel;
  logic [8:0]            tmo_inc;
  logic                  tmo_hit;

  assign in_mask_full  = size_mask(i_dport_size);
  assign cur_mask_full = size_mask(ctrl_reg.size);
  assign in_mask       = in_mask_full[ARCH-1:0];
  assign cur_mask      = cur_mask_full[ARCH-1:0];
  assign wdata_masked  = i_dport_wdata & in_mask;
  assign hart_ok       = |req_sel;
  assign accept        = ctrl_reg.req_ready && i_dport_req_valid;
  assign tmo_inc       = {1'b0, ctrl_reg.tmo_cnt} + 9'd1;
  assign tmo_hit       = (tmo_inc >= 9'(TMO));

  always_comb begin
    req_sel       = '0;
    cur_sel       = '0;
    cnt_sel       = '0;
    csr_data_sel  = '0;
    ireg_data_sel = '0;
    for (int h = 0; h < NHARTS; h++) begin
      req_sel[h] = (int'(i_dport_hartsel) == h);
      cur_sel[h] = (int'(hart_reg) == h);
      if (req_sel[h]) cnt_sel = cnt_arr[h];
      if (cur_sel[h]) begin
        csr_data_sel  = i_csr_resp_data[h*ARCH +: ARCH];
        ireg_data_sel = i_ireg_rdata[h*ARCH +: ARCH];
      end
    end
  end

  // A debug write lands in the accept cycle so it overrides any concurrent call/ret.
  assign stktr_wr = (accept && i_dport_write && (i_dport_region == REGION_STKTR)) ? req_sel : '0;

  for (genvar gi = 0; gi < NHARTS; gi++) begin : g_stktr
    stktr_counter #(.W(STKTR_LOG2)) u_cnt (
      .clk     (i_clk),
      .rst_n   (i_nrst),
      .call    (i_e_call[gi]),
      .ret     (i_e_ret[gi]),
      .wr_en   (stktr_wr[gi]),
      .wr_data (wdata_masked[STKTR_LOG2-1:0]),
      .cnt     (cnt_arr[gi])
    );
    assign o_stktr_cnt[gi*STKTR_LOG2 +: STKTR_LOG2] = cnt_arr[gi];
  end

  always_comb begin
    ctrl_next            = ctrl_reg;
    hart_next            = hart_reg;
    idx_next             = idx_reg;
    wdata_next           = wdata_reg;
    rdata_next           = rdata_reg;
    csr_req_valid_next   = csr_req_valid_reg;
    ireg_ena_next        = '0;
    ctrl_next.ireg_write = 1'b0;

    case (ctrl_reg.state)
      ST_IDLE: begin
        if (accept) begin
          hart_next                = i_dport_hartsel;
          idx_next                 = i_dport_idx;
          wdata_next               = wdata_masked;
          rdata_next               = '0;
          ctrl_next.write          = i_dport_write;
          ctrl_next.size           = i_dport_size;
          ctrl_next.error          = 1'b0;
          ctrl_next.req_ready      = 1'b0;
          ctrl_next.csr_resp_ready = 1'b0;
          if (!hart_ok || (i_dport_region == REGION_RSVD)) begin
            ctrl_next.state      = ST_RESP;
            ctrl_next.error      = 1'b1;
            ctrl_next.resp_valid = 1'b1;
          end else begin
            case (i_dport_region)
              REGION_CSR: begin
                ctrl_next.state    = ST_CSR_REQ;
                ctrl_next.tmo_cnt  = 8'd0;
                csr_req_valid_next = req_sel;
              end
              REGION_IREG: begin
                ctrl_next.state      = ST_REG_ACC;
                ctrl_next.ireg_write = i_dport_write;
                ireg_ena_next        = req_sel;
              end
              default: begin  // stack-trace counter, answered immediately
                ctrl_next.state      = ST_RESP;
                ctrl_next.resp_valid = 1'b1;
                if (!i_dport_write) begin
                  rdata_next[STKTR_LOG2-1:0] = cnt_sel;
                  rdata_next                 = rdata_next & in_mask;
                end
              end
            endcase
          end
        end
      end

      ST_CSR_REQ: begin
        if (|(i_csr_req_ready & cur_sel)) begin
          ctrl_next.state          = ST_CSR_RESP;
          ctrl_next.csr_resp_ready = 1'b1;
          ctrl_next.tmo_cnt        = tmo_inc[7:0];
          csr_req_valid_next       = '0;
        end else if (tmo_hit) begin
          ctrl_next.state      = ST_RESP;
          ctrl_next.error      = 1'b1;
          ctrl_next.resp_valid = 1'b1;
          rdata_next           = '0;
          csr_req_valid_next   = '0;
        end else begin
          ctrl_next.tmo_cnt = tmo_inc[7:0];
        end
      end

      ST_CSR_RESP: begin
        if (|(i_csr_resp_valid & cur_sel)) begin
          ctrl_next.state          = ST_RESP;
          ctrl_next.error          = |(i_csr_resp_exception & cur_sel);
          ctrl_next.resp_valid     = 1'b1;
          ctrl_next.csr_resp_ready = 1'b0;
          rdata_next               = csr_data_sel & cur_mask;
        end else if (tmo_hit) begin
          ctrl_next.state          = ST_RESP;
          ctrl_next.error          = 1'b1;
          ctrl_next.resp_valid     = 1'b1;
          ctrl_next.csr_resp_ready = 1'b0;
          rdata_next               = '0;
        end else begin
          ctrl_next.tmo_cnt = tmo_inc[7:0];
        end
      end

      ST_REG_ACC: begin
        ctrl_next.state = ST_REG_CAP;
      end

      ST_REG_CAP: begin
        // regbank data is valid the cycle after the strobe
        if (!ctrl_reg.write) rdata_next = ireg_data_sel & cur_mask;
        ctrl_next.state      = ST_RESP;
        ctrl_next.resp_valid = 1'b1;
      end

      ST_RESP: begin
        if (i_dport_resp_ready) begin
          ctrl_next.state          = ST_IDLE;
          ctrl_next.resp_valid     = 1'b0;
          ctrl_next.error          = 1'b0;
          ctrl_next.req_ready      = 1'b1;
          ctrl_next.csr_resp_ready = 1'b1;
        end
      end

      default: begin
        ctrl_next = CTRL_RESET;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      ctrl_reg          <= CTRL_RESET;
      hart_reg          <= '0;
      idx_reg           <= '0;
      wdata_reg         <= '0;
      rdata_reg         <= '0;
      csr_req_valid_reg <= '0;
      ireg_ena_reg      <= '0;
    end else begin
      ctrl_reg          <= ctrl_next;
      hart_reg          <= hart_next;
      idx_reg           <= idx_next;
      wdata_reg         <= wdata_next;
      rdata_reg         <= rdata_next;
      csr_req_valid_reg <= csr_req_valid_next;
      ireg_ena_reg      <= ireg_ena_next;
    end
  end

  assign o_dport_req_ready  = ctrl_reg.req_ready;
  assign o_dport_resp_valid = ctrl_reg.resp_valid;
  assign o_dport_resp_error = ctrl_reg.error;
  assign o_dport_rdata      = rdata_reg;
  assign o_csr_req_valid    = csr_req_valid_reg;
  assign o_csr_req_write    = ctrl_reg.write;
  assign o_csr_req_addr     = idx_reg;
  assign o_csr_req_data     = wdata_reg;
  assign o_csr_resp_ready   = ctrl_reg.csr_resp_ready;
  assign o_ireg_ena         = ireg_ena_reg;
  assign o_ireg_write       = ctrl_reg.ireg_write;
  assign o_ireg_addr        = {1'b0, idx_reg[4:0]};
  assign o_ireg_wdata       = wdata_reg;

endmodule

// File: tb/tb_dbg_port_mh.sv
module tb_dbg_port_mh;

  localparam int NH = 5;
  localparam int AW = 64;
  localparam int SL = 5;

  logic           clk = 1'b0;
  logic           nrst;
  logic           req_valid;
  logic           req_ready;
  logic [2:0]     hartsel;
  logic [1:0]     region;
  logic [11:0]    idx;
  logic           wr;
  logic [1:0]     size;
  logic [AW-1:0]  wdata;
  logic           resp_valid;
  logic           resp_ready;
  logic           resp_error;
  logic [AW-1:0]  rdata;
  logic [NH-1:0]  csr_req_valid;
  logic [NH-1:0]  csr_req_ready;
  logic           csr_req_write;
  logic [11:0]    csr_req_addr;
  logic [AW-1:0]  csr_req_data;
  logic [NH-1:0]  csr_resp_valid;
  logic           csr_resp_ready;
  logic [NH*AW-1:0] csr_resp_data;
  logic [NH-1:0]  csr_resp_exc;
  logic [NH-1:0]  ireg_ena;
  logic           ireg_write;
  logic [5:0]     ireg_addr;
  logic [AW-1:0]  ireg_wdata;
  logic [NH*AW-1:0] ireg_rdata;
  logic [NH-1:0]  e_call;
  logic [NH-1:0]  e_ret;
  logic [NH*SL-1:0] stktr_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dbg_port_mh #(.NHARTS(NH), .ARCH(AW), .STKTR_LOG2(SL), .TMO(4)) dut (
    .i_clk                (clk),
    .i_nrst               (nrst),
    .i_dport_req_valid    (req_valid),
    .o_dport_req_ready    (req_ready),
    .i_dport_hartsel      (hartsel),
    .i_dport_region       (region),
    .i_dport_idx          (idx),
    .i_dport_write        (wr),
    .i_dport_size         (size),
    .i_dport_wdata        (wdata),
    .o_dport_resp_valid   (resp_valid),
    .i_dport_resp_ready   (resp_ready),
    .o_dport_resp_error   (resp_error),
    .o_dport_rdata        (rdata),
    .o_csr_req_valid      (csr_req_valid),
    .i_csr_req_ready      (csr_req_ready),
    .o_csr_req_write      (csr_req_write),
    .o_csr_req_addr       (csr_req_addr),
    .o_csr_req_data       (csr_req_data),
    .i_csr_resp_valid     (csr_resp_valid),
    .o_csr_resp_ready     (csr_resp_ready),
    .i_csr_resp_data      (csr_resp_data),
    .i_csr_resp_exception (csr_resp_exc),
    .o_ireg_ena           (ireg_ena),
    .o_ireg_write         (ireg_write),
    .o_ireg_addr          (ireg_addr),
    .o_ireg_wdata         (ireg_wdata),
    .i_ireg_rdata         (ireg_rdata),
    .i_e_call             (e_call),
    .i_e_ret              (e_ret),
    .o_stktr_cnt          (stktr_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one cycle; returns in cycle T+1.
  task automatic send(input logic [2:0] h, input logic [1:0] rg, input logic [11:0] ix,
                      input logic w, input logic [1:0] sz, input logic [63:0] wd);
    hartsel = h; region = rg; idx = ix; wr = w; size = sz; wdata = wd;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    $display("req hart=%0d region=%0d idx=%h write=%0d size=%0d wdata=%h", h, rg, ix, w, sz, wd);
  endtask

  task automatic take_resp(input string tag);
    $display("resp %s valid=%0d error=%0d rdata=%h", tag, resp_valid, resp_error, rdata);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk({tag, "_drop"}, 64'(resp_valid), 64'd0);
    chk({tag, "_idle"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    nrst = 1'b0; req_valid = 1'b0; hartsel = '0; region = '0; idx = '0; wr = 1'b0;
    size = '0; wdata = '0; resp_ready = 1'b0; csr_req_ready = '0; csr_resp_valid = '0;
    csr_resp_data = '0; csr_resp_exc = '0; ireg_rdata = '0; e_call = '0; e_ret = '0;

    // Reset state
    step(); step();
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_csr_resp_ready", 64'(csr_resp_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_csr_req_valid", 64'(csr_req_valid), 64'd0);
    chk("rst_ireg_ena", 64'(ireg_ena), 64'd0);
    chk("rst_stktr", 64'(stktr_cnt), 64'd0);
    nrst = 1'b1;
    step();

    // Hart 2 CSR read 0x7b1, ready at T+1, response at T+2
    send(3'd2, 2'd0, 12'h7b1, 1'b0, 2'd3, 64'h0);
    chk("csr_req_valid", 64'(csr_req_valid), 64'h04);
    chk("csr_req_addr", 64'(csr_req_addr), 64'h7b1);
    chk("csr_req_busy", 64'(req_ready), 64'd0);
    csr_req_ready = 5'b00100;
    step();
    csr_req_ready = '0;
    chk("csr_req_drop", 64'(csr_req_valid), 64'd0);
    chk("csr_resp_ready", 64'(csr_resp_ready), 64'd1);
    chk("csr_t2_no_resp", 64'(resp_valid), 64'd0);
    csr_resp_valid = 5'b00100;
    csr_resp_data[2*AW +: AW] = 64'h0000_0000_8000_0010;
    csr_resp_data[1*AW +: AW] = 64'h1111_1111_1111_1111;
    step();
    csr_resp_valid = '0;
    chk("csr_resp_valid", 64'(resp_valid), 64'd1);
    chk("csr_rdata", rdata, 64'h8000_0010);
    chk("csr_error", 64'(resp_error), 64'd0);
    step();
    chk("csr_hold_valid", 64'(resp_valid), 64'd1);
    chk("csr_hold_rdata", rdata, 64'h8000_0010);
    take_resp("csr_rd");

    // Timeout: hart 0 CSR read, no ready ever (TMO=4)
    send(3'd0, 2'd0, 12'h300, 1'b0, 2'd3, 64'h0);
    step(); step(); step();
    chk("tmo_still_req", 64'(csr_req_valid), 64'h01);
    chk("tmo_no_resp_yet", 64'(resp_valid), 64'd0);
    step();
    chk("tmo_resp_valid", 64'(resp_valid), 64'd1);
    chk("tmo_error", 64'(resp_error), 64'd1);
    chk("tmo_rdata", rdata, 64'd0);
    chk("tmo_req_drop", 64'(csr_req_valid), 64'd0);
    take_resp("tmo");
    // late response drained in IDLE
    chk("late_ready", 64'(csr_resp_ready), 64'd1);
    csr_resp_valid = 5'b00001;
    csr_resp_data[0 +: AW] = 64'h55;
    step();
    csr_resp_valid = '0;
    step();
    chk("late_no_resp", 64'(resp_valid), 64'd0);
    chk("late_idle", 64'(req_ready), 64'd1);

    // Hart 1 regbank read x5, size 2
    ireg_rdata[1*AW +: AW] = 64'hDEAD_BEEF_1234_5678;
    ireg_rdata[0*AW +: AW] = 64'hFFFF_FFFF_FFFF_FFFF;
    send(3'd1, 2'd1, 12'd5, 1'b0, 2'd2, 64'h0);
    chk("ireg_ena", 64'(ireg_ena), 64'h02);
    chk("ireg_addr", 64'(ireg_addr), 64'd5);
    chk("ireg_rd_nowrite", 64'(ireg_write), 64'd0);
    step();
    chk("ireg_ena_1cyc", 64'(ireg_ena), 64'd0);
    chk("ireg_t2_no_resp", 64'(resp_valid), 64'd0);
    step();
    chk("ireg_resp_valid", 64'(resp_valid), 64'd1);
    chk("ireg_rdata", rdata, 64'h1234_5678);
    take_resp("ireg_rd");

    // Invalid hart 5
    send(3'd5, 2'd0, 12'h7b1, 1'b0, 2'd3, 64'h0);
    chk("badhart_valid", 64'(resp_valid), 64'd1);
    chk("badhart_error", 64'(resp_error), 64'd1);
    chk("badhart_rdata", rdata, 64'd0);
    chk("badhart_csr", 64'(csr_req_valid), 64'd0);
    chk("badhart_ireg", 64'(ireg_ena), 64'd0);
    take_resp("badhart");

    // Reserved region
    send(3'd0, 2'd3, 12'h0, 1'b0, 2'd3, 64'h0);
    chk("rsvd_valid", 64'(resp_valid), 64'd1);
    chk("rsvd_error", 64'(resp_error), 64'd1);
    chk("rsvd_csr", 64'(csr_req_valid), 64'd0);
    chk("rsvd_ireg", 64'(ireg_ena), 64'd0);
    take_resp("rsvd");

    // Regbank write hart 3 x7, size 1 -> wdata masked to 16 bits
    send(3'd3, 2'd1, 12'd7, 1'b1, 2'd1, 64'hAAAA_BBBB_CCCC_DDDD);
    chk("iwr_ena", 64'(ireg_ena), 64'h08);
    chk("iwr_write", 64'(ireg_write), 64'd1);
    chk("iwr_wdata", ireg_wdata, 64'hDDDD);
    chk("iwr_addr", 64'(ireg_addr), 64'd7);
    step();
    chk("iwr_write_drop", 64'(ireg_write), 64'd0);
    step();
    chk("iwr_resp_valid", 64'(resp_valid), 64'd1);
    chk("iwr_error", 64'(resp_error), 64'd0);
    take_resp("ireg_wr");

    // Stack-trace counters
    e_call = 5'b00001;
    repeat (33) step();
    e_call = '0;
    chk("stk_sat", 64'(stktr_cnt[0 +: SL]), 64'd31);
    e_call = 5'b00001; e_ret = 5'b00001;
    step();
    e_call = '0; e_ret = '0;
    chk("stk_callret", 64'(stktr_cnt[0 +: SL]), 64'd31);
    e_ret = 5'b00001;
    step();
    e_ret = '0;
    chk("stk_ret", 64'(stktr_cnt[0 +: SL]), 64'd30);
    e_call = 5'b00001;
    send(3'd0, 2'd2, 12'h0, 1'b1, 2'd0, 64'h3);
    e_call = '0;
    chk("stk_wr_override", 64'(stktr_cnt[0 +: SL]), 64'd3);
    chk("stk_wr_valid", 64'(resp_valid), 64'd1);
    chk("stk_wr_error", 64'(resp_error), 64'd0);
    take_resp("stk_wr");
    send(3'd0, 2'd2, 12'h0, 1'b0, 2'd3, 64'h0);
    chk("stk_rd_valid", 64'(resp_valid), 64'd1);
    chk("stk_rd_data", rdata, 64'd3);
    take_resp("stk_rd0");
    e_ret = 5'b00010;
    step();
    e_ret = '0;
    chk("stk_floor", 64'(stktr_cnt[1*SL +: SL]), 64'd0);
    e_call = 5'b00010;
    step(); step();
    e_call = '0;
    chk("stk_h1_cnt", 64'(stktr_cnt[1*SL +: SL]), 64'd2);
    send(3'd1, 2'd2, 12'h0, 1'b0, 2'd0, 64'h0);
    chk("stk_h1_rd", rdata, 64'd2);
    take_resp("stk_rd1");

    // Reset while in CSR_RESP
    send(3'd2, 2'd0, 12'h7b1, 1'b0, 2'd3, 64'h0);
    csr_req_ready = 5'b00100;
    step();
    csr_req_ready = '0;
    chk("mid_in_resp_wait", 64'(csr_resp_ready), 64'd1);
    nrst = 1'b0;
    #1;
    chk("mid_rst_idle", 64'(req_ready), 64'd1);
    chk("mid_rst_csr_req", 64'(csr_req_valid), 64'd0);
    chk("mid_rst_stktr", 64'(stktr_cnt), 64'd0);
    #1;
    nrst = 1'b1;
    csr_resp_valid = 5'b00100;
    step();
    csr_resp_valid = '0;
    step();
    chk("mid_no_resp", 64'(resp_valid), 64'd0);
    chk("mid_idle", 64'(req_ready), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
